data_mem_responder: RTL

//  Memory-side responder for the RV32I multi-cycle core's load/store path. Accepts one request
//  (addr, wdata, mem_WE, mem_MODE) at a time and executes it against a word-wide,

---
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for the RV32I core: one request at a time, misaligned accesses split into two
// byte-enabled SRAM beats, response is a single-cycle pulse carrying extended load data or a store ack.
module data_mem_responder #(
   parameter int AW       = 10,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   input  logic          mem_WE,
   input  logic [2:0]    mem_MODE,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [31:0]   rdata,
   output logic          sram_en,
   output logic          sram_we,
   output logic [3:0]    sram_be,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);

   typedef enum logic [1:0] {IDLE, B0, B1, RESP} state_t;

   state_t          state, state_nxt;
   logic [AW+1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic            we_q;
   logic [2:0]      mode_q;
   logic            err_q;
   logic            split_q;
   logic [31:0]     beat0_q;

   logic            accept;
   logic            in_mis;
   logic            in_cross;
   logic [7:0]      in_mask;
   logic [7:0]      lane_mask;
   logic [63:0]     lane_data;
   logic [63:0]     ld_shift;
   logic [31:0]     ld_lo;
   logic [31:0]     ld_hi;
   logic [31:0]     ld_ext;
   logic [AW-1:0]   word_a;
   logic            unused_addr_hi;

   assign unused_addr_hi = ^addr[31:AW+2];

   // size field 11 is treated as a word access
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b0001;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   assign accept    = req_valid && (state == IDLE);
   assign req_ready = (state == IDLE);

   always_comb begin
      in_mask  = {4'b0000, size_mask(mem_MODE[1:0])} << addr[1:0];
      in_cross = |in_mask[7:4];
      case (mem_MODE[1:0])
         2'b01:   in_mis = addr[0];
         2'b10:   in_mis = 1'b0;
         default: in_mis = (addr[1:0] != 2'b00);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         mode_q  <= '0;
         err_q   <= 1'b0;
         split_q <= 1'b0;
         beat0_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            we_q    <= mem_WE;
            mode_q  <= mem_MODE;
            err_q   <= !SPLIT_EN && in_mis;
            split_q <= in_cross;
         end
         // beat0 read data arrives during B1 and must be held for the RESP merge
         if (state == B1) beat0_q <= sram_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (!SPLIT_EN && in_mis) ? RESP : B0;
         B0:   state_nxt = split_q ? B1 : RESP;
         B1:   state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lane_mask = {4'b0000, size_mask(mode_q[1:0])} << addr_q[1:0];
      lane_data = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
      word_a    = addr_q[AW+1:2];
      ld_lo     = split_q ? beat0_q : sram_rdata;
      ld_hi     = split_q ? sram_rdata : 32'b0;
      ld_shift  = {ld_hi, ld_lo} >> {addr_q[1:0], 3'b000};
      case (mode_q[1:0])
         2'b01:   ld_ext = {{16{mode_q[2] & ld_shift[15]}}, ld_shift[15:0]};
         2'b10:   ld_ext = {{24{mode_q[2] & ld_shift[7]}},  ld_shift[7:0]};
         default: ld_ext = ld_shift[31:0];
      endcase
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = 4'b0000;
      sram_addr  = '0;
      sram_wdata = 32'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rdata      = 32'b0;
      case (state)
         B0: begin
            sram_en    = 1'b1;
            sram_we    = we_q;
            sram_be    = lane_mask[3:0];
            sram_addr  = word_a;
            sram_wdata = lane_data[31:0];
         end
         B1: begin
            sram_en    = 1'b1;
            sram_we    = we_q;
            sram_be    = lane_mask[7:4];
            sram_addr  = word_a + {{(AW-1){1'b0}}, 1'b1};
            sram_wdata = lane_data[63:32];
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q && !we_q) rdata = ld_ext;
         end
         default: ;
      endcase
   end

endmodule
